// File: rtl/atwd_pkg.sv
// Shared ATWD readout constants: state encoding, channel/sample geometry and
// the buffer write-word layout.
package atwd_pkg;

  localparam int ATWD_SAMPLES  = 128;
  localparam int ATWD_CHANNELS = 4;
  localparam int ATWD_IDX_W    = 7;
  localparam int ATWD_DATA_W   = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SAMPLE,
    ST_NEXT,
    ST_DONE
  } atwd_state_t;

  typedef struct packed {
    logic [1:0]             ch;
    logic [3:0]             rsvd;
    logic [ATWD_DATA_W-1:0] sample;
  } atwd_word_t;

  function automatic logic [15:0] atwd_word(input logic [1:0] ch,
                                            input logic [ATWD_DATA_W-1:0] sample);
    atwd_word_t w;
    w.ch     = ch;
    w.rsvd   = '0;
    w.sample = sample;
    return w;
  endfunction

endpackage

// File: rtl/atwd_ch_pick.sv
// Lowest set bit of mask at or above channel index 'from' (from=4 finds nothing).
// Purely combinational, no latency, no flow control.
module atwd_ch_pick
  import atwd_pkg::*;
(
  input  logic [ATWD_CHANNELS-1:0] mask,
  input  logic [2:0]               from,
  output logic                     found,
  output logic [1:0]               ch
);

  always_comb begin
    found = 1'b0;
    ch    = 2'd0;
    // Scan downward so the lowest qualifying channel is the last assignment.
    for (int i = ATWD_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) begin
        found = 1'b1;
        ch    = 2'(i);
      end
    end
  end

endmodule

// File: rtl/atwd_readout_writer.sv
// Reads enabled ATWD channels sample by sample into the buffer write port;
// 1-cycle latency atwd_valid -> wren, no backpressure (a stalled ATWD times out).
module atwd_readout_writer
  import atwd_pkg::*;
#(
  parameter int SAMPLES = ATWD_SAMPLES,
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  ch_mask,
  input  logic [9:0]  atwd_data,
  input  logic        atwd_valid,
  output logic [1:0]  ch_sel,
  output logic        rd_en,
  output logic [15:0] data,
  output logic [8:0]  wraddress,
  output logic        wren,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  atwd_state_t           state, state_nx;
  logic [ATWD_IDX_W-1:0] idx, idx_nx;
  logic [TW-1:0]         tcnt, tcnt_nx;
  logic [3:0]            mask_q, mask_nx;
  logic [1:0]            ch_nx;
  logic [15:0]           data_nx;
  logic [8:0]            addr_nx;
  logic                  wren_nx, terr_nx;

  logic                  pick_found;
  logic [1:0]            pick_ch;
  logic [3:0]            pick_mask;
  logic [2:0]            pick_from;

  // From IDLE search the live mask from channel 0; afterwards the latched mask above ch_sel.
  assign pick_mask = (state == ST_IDLE) ? ch_mask : mask_q;
  assign pick_from = (state == ST_IDLE) ? 3'd0 : ({1'b0, ch_sel} + 3'd1);

  atwd_ch_pick u_pick (
    .mask  (pick_mask),
    .from  (pick_from),
    .found (pick_found),
    .ch    (pick_ch)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ch_nx    = ch_sel;
    idx_nx   = idx;
    tcnt_nx  = tcnt;
    mask_nx  = mask_q;
    data_nx  = data;
    addr_nx  = wraddress;
    wren_nx  = 1'b0;
    terr_nx  = timeout_err;
    rd_en    = (state == ST_SAMPLE);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);

    case (state)
      ST_IDLE: begin
        if (start) begin
          terr_nx = 1'b0;
          mask_nx = ch_mask;
          if (pick_found) begin
            ch_nx    = pick_ch;
            state_nx = ST_SELECT;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_SELECT: begin
        idx_nx   = '0;
        tcnt_nx  = '0;
        state_nx = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // A valid always wins over an expiring timeout in the same cycle.
        if (atwd_valid) begin
          data_nx = atwd_word(ch_sel, atwd_data);
          addr_nx = {ch_sel, idx};
          wren_nx = 1'b1;
          idx_nx  = idx + 7'd1;
          tcnt_nx = '0;
          if (idx == 7'(SAMPLES - 1)) state_nx = ST_NEXT;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          terr_nx  = 1'b1;
          state_nx = ST_DONE;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      ST_NEXT: begin
        if (pick_found) begin
          ch_nx    = pick_ch;
          state_nx = ST_SELECT;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase

    if (abort) begin
      state_nx = ST_IDLE;
      wren_nx  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ch_sel      <= 2'd0;
      idx         <= '0;
      tcnt        <= '0;
      mask_q      <= 4'd0;
      data        <= 16'd0;
      wraddress   <= 9'd0;
      wren        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ch_sel      <= ch_nx;
      idx         <= idx_nx;
      tcnt        <= tcnt_nx;
      mask_q      <= mask_nx;
      data        <= data_nx;
      wraddress   <= addr_nx;
      wren        <= wren_nx;
      timeout_err <= terr_nx;
    end
  end

endmodule

// File: tb/tb_atwd_readout_writer.sv
// Directed-random bench for atwd_readout_writer with a write-list reference model.
module tb_atwd_readout_writer;

  localparam int TO = 255;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  ch_mask = 4'd0;
  logic [9:0]  atwd_data = 10'd0;
  logic        atwd_valid = 1'b0;
  logic [1:0]  ch_sel;
  logic        rd_en;
  logic [15:0] data;
  logic [8:0]  wraddress;
  logic        wren;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [8:0]  obs_addr[$];
  logic [15:0] obs_data[$];
  logic [1:0]  obs_ch[$];
  int          done_cnt = 0;
  logic        rd_en_prev = 1'b0;

  logic [8:0]  exp_addr[$];
  logic [15:0] exp_data[$];
  logic [1:0]  exp_ch[$];

  int wbase, dbase, cbase, cnt;

  atwd_readout_writer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .ch_mask     (ch_mask),
    .atwd_data   (atwd_data),
    .atwd_valid  (atwd_valid),
    .ch_sel      (ch_sel),
    .rd_en       (rd_en),
    .data        (data),
    .wraddress   (wraddress),
    .wren        (wren),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wren) begin
      obs_addr.push_back(wraddress);
      obs_data.push_back(data);
    end
    if (done) done_cnt++;
    if (rd_en && !rd_en_prev) obs_ch.push_back(ch_sel);
    rd_en_prev = rd_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one sample as soon as the DUT requests data, after 'gap' idle request cycles.
  // Stray valids/starts are injected while waiting; the DUT must ignore them.
  task automatic do_sample(input logic [9:0] d, input int gap);
    int g = gap;
    for (int t = 0; t < 60; t++) begin
      @(negedge clock);
      atwd_valid = 1'b0;
      start      = 1'b0;
      if (rd_en) begin
        if (g > 0) begin
          g--;
          start = 1'($urandom_range(0, 1));
        end else begin
          atwd_valid = 1'b1;
          atwd_data  = d;
          return;
        end
      end else begin
        atwd_valid = 1'($urandom_range(0, 1));
        atwd_data  = 10'($urandom);
      end
    end
    chk("rd_en_wait", 32'd0, 32'd1);
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    atwd_valid = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic begin_run(input logic [3:0] m);
    exp_addr.delete();
    exp_data.delete();
    exp_ch.delete();
    wbase = obs_addr.size();
    dbase = done_cnt;
    cbase = obs_ch.size();
    @(negedge clock);
    atwd_valid = 1'b0;
    start      = 1'b1;
    ch_mask    = m;
  endtask

  // Feeds n samples of channel c, recording the write the buffer should receive for each.
  task automatic feed_channel(input int c, input int n, input bit idx_data);
    logic [9:0] d;
    exp_ch.push_back(2'(c));
    for (int i = 0; i < n; i++) begin
      d = idx_data ? 10'((c * 128 + i) % 1024) : 10'($urandom);
      exp_addr.push_back(9'(c * 128 + i));
      exp_data.push_back({2'(c), 4'b0000, d});
      do_sample(d, $urandom_range(0, 2));
    end
  endtask

  task automatic check_writes(input string tag);
    int n = obs_addr.size() - wbase;
    chk({tag, "_nwrites"}, 32'(n), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < n; i++) begin
      chk({tag, "_addr"}, 32'(obs_addr[wbase + i]), 32'(exp_addr[i]));
      chk({tag, "_data"}, 32'(obs_data[wbase + i]), 32'(exp_data[i]));
    end
  endtask

  task automatic full_run(input string tag, input logic [3:0] m, input bit idx_data);
    begin_run(m);
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_terr_cleared"}, 32'(timeout_err), 32'd0);
    for (int c = 0; c < 4; c++)
      if (m[c]) feed_channel(c, 128, idx_data);
    for (int t = 0; t < 20; t++) begin
      idle_cycle();
      if (!busy) break;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    check_writes(tag);
    chk({tag, "_done_cnt"}, 32'(done_cnt - dbase), 32'd1);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
    chk({tag, "_nch"}, 32'(obs_ch.size() - cbase), 32'(exp_ch.size()));
    for (int i = 0; i < exp_ch.size() && cbase + i < obs_ch.size(); i++)
      chk({tag, "_ch_seq"}, 32'(obs_ch[cbase + i]), 32'(exp_ch[i]));
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {rd_en, wren, done, timeout_err, ch_sel}, 32'd0);
    chk("rst_data", {7'd0, wraddress, data}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle_cycle();
    chk("idle_busy", 32'(busy), 32'd0);

    // All four channels, data = sample index mod 1024
    full_run("all4", 4'b1111, 1'b1);

    // Masked channels skipped: only channels 0 and 2
    full_run("m0101", 4'b0101, 1'b0);

    // Timeout: 50 samples then silence
    begin_run(4'b0001);
    feed_channel(0, 50, 1'b0);
    cnt = -1;
    for (int t = 0; t < 400; t++) begin
      idle_cycle();
      if (done) begin
        cnt = t;
        break;
      end
    end
    chk("to_latency", 32'(cnt), 32'(TO));
    idle_cycle();
    chk("to_terr", 32'(timeout_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_done_cnt", 32'(done_cnt - dbase), 32'd1);
    check_writes("to");

    // Sticky error cleared by the next accepted start
    full_run("after_to", 4'b0101, 1'b0);

    // Abort (together with start) at sample 70 of channel 1
    begin_run(4'b0011);
    feed_channel(0, 128, 1'b0);
    feed_channel(1, 70, 1'b0);
    idle_cycle();
    idle_cycle();
    chk("ab_pre_busy", 32'(busy), 32'd1);
    @(negedge clock);
    abort = 1'b1;
    start = 1'b1;
    idle_cycle();
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_rd_en", 32'(rd_en), 32'd0);
    chk("ab_wren", 32'(wren), 32'd0);
    for (int t = 0; t < 5; t++) idle_cycle();
    chk("ab_no_done", 32'(done_cnt - dbase), 32'd0);
    check_writes("ab");
    full_run("post_ab", 4'($urandom_range(1, 15)), 1'b0);

    // Random masks
    for (int r = 0; r < 3; r++)
      full_run("rnd", 4'($urandom_range(1, 15)), 1'b0);

    // Reset asserted mid-readout clears outputs asynchronously
    begin_run(4'b1000);
    feed_channel(3, 10, 1'b0);
    idle_cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_outs", {rd_en, wren, done, timeout_err, ch_sel}, 32'd0);
    chk("arst_data", {7'd0, wraddress, data}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Empty mask: done after one cycle, no writes
    begin_run(4'b0000);
    idle_cycle();
    chk("empty_done", 32'(done), 32'd1);
    idle_cycle();
    chk("empty_done_off", {busy, done}, 32'd0);
    chk("empty_nwrites", 32'(obs_addr.size() - wbase), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/atwd_readout_writer.md
ATWD_READOUT_WRITER -- requirements
Module: atwd_readout_writer

Interface
REQ-001 Parameter SAMPLES, default 128, samples per ATWD channel; 128 is the only supported value.
REQ-002 Parameter TIMEOUT, default 255, maximum idle cycles between atwd_valid strobes.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse; begins readout of one digitized ATWD launch.
REQ-006 abort  input  1  level; forces return to IDLE.
REQ-007 ch_mask  input  4  per-channel readout enable; bit n selects channel n.
REQ-008 atwd_data  input  10  digitized sample from ATWD readout shifter.
REQ-009 atwd_valid  input  1  qualifies atwd_data for exactly one cycle.
REQ-010 ch_sel  output  2  channel currently being read out.
REQ-011 rd_en  output  1  requests samples from the ATWD for channel ch_sel.
REQ-012 data  output  16  buffer write word: {ch_sel, 4'b0000, atwd_data}.
REQ-013 wraddress  output  9  buffer write address: {ch_sel, sample_idx[6:0]}.
REQ-014 wren  output  1  buffer write strobe, one cycle per sample.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on completion or timeout.
REQ-017 timeout_err  output  1  sticky; set on timeout, cleared by next accepted start.

Function
REQ-018 FSM states: IDLE, SELECT, SAMPLE, NEXT, DONE.
REQ-019 IDLE: start=1 with ch_mask!=0 -> SELECT; clears timeout_err; ch_sel loads lowest set bit of ch_mask.
REQ-020 IDLE: start=1 with ch_mask==0 -> DONE directly; no writes.
REQ-021 SELECT: one cycle; sample_idx=0, timeout counter=0 -> SAMPLE.
REQ-022 SAMPLE: rd_en=1; each atwd_valid registers data/wraddress and pulses wren on the next cycle (latency 1); sample_idx increments.
REQ-023 SAMPLE: valid for sample_idx=127 -> NEXT; wrap of the 7-bit index never produces a 129th write.
REQ-024 NEXT: rd_en=0; next higher set bit of ch_mask -> SELECT with new ch_sel; none remaining -> DONE.
REQ-025 Masked channels are skipped; their 128-word address region is not written.
REQ-026 Timeout counter resets on each atwd_valid; reaching TIMEOUT in SAMPLE sets timeout_err -> DONE, leaving partial data written.
REQ-027 DONE: done=1 for one cycle -> IDLE.
REQ-028 start outside IDLE is ignored.
REQ-029 atwd_valid outside SAMPLE is ignored and causes no write.
REQ-030 abort=1 in any state -> IDLE next cycle; wren is suppressed that cycle; no done pulse.
REQ-031 abort and start in the same cycle: abort wins.
REQ-032 The last-sample valid and a timeout in the same cycle: the sample is written; no timeout.

Reset
REQ-033 reset_n=0 forces state=IDLE, ch_sel=0, sample_idx=0, timeout counter=0, and all outputs 0 (data and wraddress 0; rd_en, wren, busy, done, timeout_err 0).
REQ-034 Reset assertion mid-readout discards the readout immediately; buffer contents are undefined afterwards.

Structure
REQ-035 State encoding, SAMPLES, the channel count (4) and the data-word field layout live in the shared ATWD constants package.
REQ-036 One sub-module, atwd_ch_pick, is natural: combinational next-set-bit search over ch_mask above a given channel.
REQ-037 Outputs data, wraddress and wren connect directly to the ATWD_buffer write port; the block contains no memory.

Verification
REQ-038 ch_mask=4'b1111, 512 valids with data=idx mod 1024 -> 512 writes at addresses 0..511, data[15:14]=channel, single done, timeout_err=0.
REQ-039 ch_mask=4'b0101 -> writes only at 0..127 and 256..383; ch_sel sequence 0 then 2; single done.
REQ-040 ch_mask=4'b0001, valids stop after 50 samples -> done after 255 idle cycles, timeout_err=1, exactly 50 writes.
REQ-041 abort at sample 70 of channel 1 -> IDLE next cycle; no done; a following start/readout completes normally.
REQ-042 reset_n low during SAMPLE -> all outputs 0 asynchronously; start=1 with ch_mask=0 -> done after 1 cycle, no wren.
